// File: rtl/uart_port_arbiter.sv
// uart_port_arbiter
// Shares one UART between several BLE-side requesters. TX ownership is
// granted round-robin per packet and held until the owner drops its request,
// with a watchdog that reclaims stalled grants. RX FIFO read-enable ownership
// follows the last TX packet completed with LF, otherwise the default consumer.
module uart_port_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DEF_RX     = 0,
   parameter int TMO_CYCLES = 1_000_000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           tx_valid,
   input  logic [8*N_REQ-1:0]         tx_data,
   output logic [N_REQ-1:0]           grant,
   output logic [7:0]                 tx_sys_data,
   output logic                       valid_tx,
   input  logic                       tx_full,
   input  logic [N_REQ-1:0]           rx_rd_en,
   input  logic [7:0]                 rx_sys_data,
   output logic                       rd_fifo_rd_en,
   output logic [$clog2(N_REQ)-1:0]   rx_owner,
   output logic                       timeout_err
);

   localparam int DATA_W = 8;
   localparam int IDX_W  = $clog2(N_REQ);
   localparam int WD_W   = $clog2(TMO_CYCLES + 1);

   localparam logic [DATA_W-1:0] LF      = 8'h0A;
   localparam logic [IDX_W-1:0]  DEF_IDX = IDX_W'(DEF_RX);
   localparam logic [IDX_W-1:0]  LAST    = IDX_W'(N_REQ - 1);
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TMO_CYCLES - 1);
   localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(TMO_CYCLES);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [WD_W-1:0]     wdog_q, wdog_d;
   logic [IDX_W-1:0]    rx_owner_q, rx_owner_d;
   logic                tmo_q, tmo_d;

   // Owner-selected byte/valid and RX read request
   logic                sel_valid;
   logic [DATA_W-1:0]   sel_data;
   logic                rd_sel;

   // Round-robin arbitration results
   logic [N_REQ-1:0]    mask_ge;
   logic [N_REQ-1:0]    req_hi;
   logic [N_REQ-1:0]    cand;
   logic [IDX_W-1:0]    win;
   logic                win_found;
   logic [IDX_W-1:0]    win_next;

   logic                busy;
   logic                accept;
   logic                tx_lf;
   logic                rx_lf;

   // Route the owner's TX byte/valid and the RX owner's read request
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      rd_sel    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            sel_valid = tx_valid[i];
            sel_data  = tx_data[DATA_W*i +: DATA_W];
         end
         if (rx_owner_q == IDX_W'(i)) begin
            rd_sel = rx_rd_en[i];
         end
      end
   end

   assign busy          = (state_q == BUSY);
   assign accept        = busy & sel_valid & ~tx_full;
   assign tx_lf         = accept & (sel_data == LF);
   assign rd_fifo_rd_en = rd_sel;
   assign rx_lf         = rd_sel & (rx_sys_data == LF);

   assign valid_tx      = accept;
   assign tx_sys_data   = sel_data;
   assign grant         = grant_q;
   assign rx_owner      = rx_owner_q;
   assign timeout_err   = tmo_q;

   // Pick the first requester at or after rr_ptr, wrapping to the lowest index
   always_comb begin
      mask_ge   = '0;
      win       = '0;
      win_found = |req;
      for (int j = 0; j < N_REQ; j++) begin
         mask_ge[j] = (IDX_W'(j) >= rr_q);
      end
      req_hi = req & mask_ge;
      cand   = (|req_hi) ? req_hi : req;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (cand[j]) begin
            win = IDX_W'(j);
         end
      end
      win_next = (win == LAST) ? '0 : win + 1'b1;
   end

   // Next-state logic: arbitration, release, watchdog and RX ownership
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      rr_d       = rr_q;
      wdog_d     = wdog_q;
      tmo_d      = 1'b0;
      rx_owner_d = rx_owner_q;

      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d = N_REQ'(1) << win;
               owner_d = win;
               rr_d    = win_next;
               wdog_d  = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (accept) begin
               wdog_d = '0;
            end else if (wdog_q != WD_MAX) begin
               wdog_d = wdog_q + 1'b1;
            end

            // Voluntary release wins over a coincident watchdog expiry
            if (!(|(req & grant_q))) begin
               grant_d = '0;
               state_d = IDLE;
            end else if (!accept && (wdog_q >= WD_LAST)) begin
               grant_d = '0;
               tmo_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase

      // A completed TX packet claims the response over a finished RX packet
      if (tx_lf) begin
         rx_owner_d = owner_q;
      end else if (rx_lf) begin
         rx_owner_d = DEF_IDX;
      end
   end

   // State and control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         rr_q       <= '0;
         wdog_q     <= '0;
         rx_owner_q <= DEF_IDX;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         rr_q       <= rr_d;
         wdog_q     <= wdog_d;
         rx_owner_q <= rx_owner_d;
         tmo_q      <= tmo_d;
      end
   end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// tb_uart_port_arbiter
// Scoreboarded bench: bytes handed to the arbiter are queued as expected
// output and compared in order as the UART write strobe fires.
module tb_uart_port_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   tx_valid;
   logic [8*N-1:0] tx_data;
   logic [N-1:0]   grant;
   logic [7:0]     tx_sys_data;
   logic           valid_tx;
   logic           tx_full = 1'b0;
   logic [N-1:0]   rx_rd_en;
   logic [7:0]     rx_sys_data;
   logic           rd_fifo_rd_en;
   logic [1:0]     rx_owner;
   logic           timeout_err;

   int             n_cmp = 0;
   int             n_err = 0;
   logic [7:0]     sb_q[$];

   logic           bp_en = 1'b0;
   int             bp_cnt = 0;

   logic [7:0]     at_s[4] = '{8'h41, 8'h54, 8'h0D, 8'h0A};
   logic [7:0]     ok_s[4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};

   uart_port_arbiter #(
      .N_REQ      (N),
      .DEF_RX     (0),
      .TMO_CYCLES (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .grant         (grant),
      .tx_sys_data   (tx_sys_data),
      .valid_tx      (valid_tx),
      .tx_full       (tx_full),
      .rx_rd_en      (rx_rd_en),
      .rx_sys_data   (rx_sys_data),
      .rd_fifo_rd_en (rd_fifo_rd_en),
      .rx_owner      (rx_owner),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a byte from requester r and hold it until the UART accepts it
   task automatic send_byte(input int r, input logic [7:0] b, output int waited);
      waited = 0;
      tx_data[8*r +: 8] = b;
      tx_valid[r] = 1'b1;
      sb_q.push_back(b);
      forever begin
         @(negedge clk);
         if (valid_tx) break;
         waited++;
         if (waited > 50) begin
            check_eq("send_budget", waited, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      tx_valid[r] = 1'b0;
   endtask

   // tx_full toggles every 3 cycles while backpressure is enabled
   always @(posedge clk) begin
      #1;
      if (!bp_en) begin
         bp_cnt  <= 0;
         tx_full <= 1'b0;
      end else if (bp_cnt == 2) begin
         bp_cnt  <= 0;
         tx_full <= ~tx_full;
      end else begin
         bp_cnt  <= bp_cnt + 1;
      end
   end

   // Output monitor: grant exclusivity, no write while full, byte order
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check_eq("grant_onehot0", 32'($onehot0(grant)), 1);
         if (valid_tx) begin
            check_eq("tx_while_full", tx_full, 0);
            check_eq("sb_has_entry", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) check_eq("tx_byte", tx_sys_data, sb_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, got n_cmp=%0d, expected completion", n_cmp);
      $fatal(1, "bench timeout");
   end

   initial begin
      int w;
      int tot;
      rst_n       = 1'b0;
      req         = '0;
      tx_valid    = '0;
      tx_data     = '0;
      rx_rd_en    = '0;
      rx_sys_data = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_grant", grant, 0);
      check_eq("rst_valid_tx", valid_tx, 0);
      check_eq("rst_rx_owner", rx_owner, 0);
      check_eq("rst_timeout", timeout_err, 0);
      check_eq("rst_rd_en", rd_fifo_rd_en, 0);
      rst_n = 1'b1;
      tick();

      // Round-robin fairness: 0,1,2,3,0
      req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         check_eq("rr_grant", grant, 32'(1) << (k % 4));
         send_byte(k % 4, 8'h30 + 8'(k), w);
         check_eq("rr_byte_gap", w, 0);
         req[k % 4] = 1'b0;
         tick();
         check_eq("rr_release", grant, 0);
         if (k < 4) req[k % 4] = 1'b1;
         tick();
      end
      req = '0;
      tick();

      // Single requester sends "AT\r\n"
      req = 4'b0010;
      #1;
      check_eq("at_no_grant_yet", grant, 0);
      tick();
      check_eq("at_grant", grant, 4'b0010);
      for (int i = 0; i < 4; i++) begin
         send_byte(1, at_s[i], w);
         check_eq("at_gap", w, 0);
      end
      check_eq("at_rx_owner", rx_owner, 1);
      req = '0;
      tick();
      check_eq("at_release", grant, 0);

      // RX routing follows owner 1 until its LF is read
      rx_sys_data = ok_s[0];
      rx_rd_en    = 4'b0001;
      #1;
      check_eq("rx_nonowner_blocked", rd_fifo_rd_en, 0);
      for (int i = 0; i < 4; i++) begin
         rx_sys_data = ok_s[i];
         rx_rd_en    = 4'b0011;
         #1;
         check_eq("rx_owner_read", rd_fifo_rd_en, 1);
         tick();
         check_eq("rx_owner_after", rx_owner, (i == 3) ? 0 : 1);
      end
      rx_sys_data = 8'h00;
      rx_rd_en    = 4'b0010;
      #1;
      check_eq("rx_old_owner_blocked", rd_fifo_rd_en, 0);
      rx_rd_en    = 4'b0001;
      #1;
      check_eq("rx_default_read", rd_fifo_rd_en, 1);
      rx_rd_en    = '0;
      tick();

      // TX LF accept and RX LF read in the same cycle: TX owner wins
      req = 4'b0100;
      tick();
      check_eq("pri_grant", grant, 4'b0100);
      rx_sys_data = 8'h0A;
      rx_rd_en    = 4'b0001;
      send_byte(2, 8'h0A, w);
      rx_rd_en    = '0;
      rx_sys_data = 8'h00;
      check_eq("pri_rx_owner", rx_owner, 2);
      req = '0;
      tick();

      // Backpressure: 8 bytes while tx_full toggles
      req = 4'b1000;
      tick();
      check_eq("bp_grant", grant, 4'b1000);
      bp_en = 1'b1;
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         send_byte(3, 8'h80 + 8'(i), w);
         tot += w;
      end
      check_eq("bp_stalled", tot > 0, 1);
      bp_en = 1'b0;
      req = '0;
      tick();
      check_eq("bp_release", grant, 0);
      tick();

      // Watchdog: owner 2 never sends, requester 3 waiting
      req = 4'b0100;
      tick();
      check_eq("wd_grant", grant, 4'b0100);
      req = 4'b1100;
      for (int c = 1; c <= 15; c++) begin
         tick();
         check_eq("wd_no_pulse", timeout_err, 0);
         check_eq("wd_hold", grant, 4'b0100);
      end
      tick();
      check_eq("wd_pulse", timeout_err, 1);
      check_eq("wd_revoked", grant, 0);
      tick();
      check_eq("wd_pulse_end", timeout_err, 0);
      check_eq("wd_next_grant", grant, 4'b1000);
      req = '0;
      tick();
      tick();

      // Async reset mid-packet
      check_eq("pre_rst_rx_owner", rx_owner, 2);
      req = 4'b0001;
      tick();
      check_eq("ar_grant", grant, 4'b0001);
      send_byte(0, 8'h4D, w);
      tx_data[7:0] = 8'h59;
      tx_valid[0]  = 1'b1;
      #1;
      check_eq("ar_valid_before", valid_tx, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("ar_grant_drop", grant, 0);
      check_eq("ar_valid_drop", valid_tx, 0);
      check_eq("ar_rx_owner", rx_owner, 0);
      tx_valid = '0;
      req      = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req   = 4'b0100;
      tick();
      check_eq("ar_regrant", grant, 4'b0100);
      req = '0;
      tick();
      tick();

      check_eq("sb_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_port_arbiter.md
# uart_port_arbiter

Shares the single UART instance between the BLE-side requesters (setup sequencer, setup controller, command memory, connection monitor, processor). TX is granted round-robin per packet: a winner keeps the TX path until it drops its request, and a watchdog reclaims stalled grants. RX FIFO read-enable ownership follows the last completed TX packet so each command's response reaches its sender; otherwise RX goes to a default consumer. It replaces the ad-hoc TX/RX select muxes between those modules and the UART.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DEF_RX, 0, requester index owning RX when no response is pending (must be < N_REQ)
- TMO_CYCLES, 1_000_000, clock cycles a granted requester may go without an accepted byte before revocation (≥ 2)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester TX ownership request, level
- tx_valid  in  N_REQ  per-requester byte valid
- tx_data  in  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i]
- grant  out  N_REQ  one-hot (or zero) TX ownership, registered
- tx_sys_data  out  8  byte to UART TX FIFO
- valid_tx  out  1  write strobe to UART TX FIFO
- tx_full  in  1  UART TX FIFO full
- rx_rd_en  in  N_REQ  per-requester RX FIFO read request
- rx_sys_data  in  8  UART RX FIFO head byte
- rd_fifo_rd_en  out  1  read enable to UART RX FIFO
- rx_owner  out  $clog2(N_REQ)  current RX owner index, registered
- timeout_err  out  1  one-cycle pulse on watchdog revocation

## Operation
- States: IDLE, BUSY. Reset: IDLE; grant=0, rx_owner=DEF_RX, rr_ptr=0, watchdog=0, timeout_err=0; valid_tx=0, rd_fifo_rd_en=0.
- IDLE: if any req bit set, winner = first set index scanning rr_ptr, rr_ptr+1, … modulo N_REQ; register grant=onehot(winner), rr_ptr←winner+1 (mod N_REQ), watchdog←0, → BUSY. No req: stay IDLE.
- BUSY, owner o: valid_tx = tx_valid[o] & ~tx_full; tx_sys_data = tx_data[o] (combinational). Non-owner tx_valid ignored; no byte lost or duplicated.
- Accepted byte = valid_tx high. Accepted 0x0A (LF) from o sets rx_owner←o next cycle (packet complete).
- BUSY exit on req[o]=0: grant←0, → IDLE. A byte accepted that same cycle still passes. IDLE always lasts ≥1 cycle, so arbitration reopens the cycle after release.
- Watchdog: counts BUSY cycles without an accepted byte, cleared on every accepted byte. At TMO_CYCLES: grant←0, timeout_err pulse, → IDLE; rr_ptr already past o. An accepted byte in the expiry cycle clears the count and prevents revocation.
- A revoked requester keeping req high re-enters arbitration normally, behind the others.
- RX: rd_fifo_rd_en = rx_rd_en[rx_owner] (combinational); other rx_rd_en ignored.
- RX release: read of 0x0A (rd_fifo_rd_en & rx_sys_data==8'h0A) sets rx_owner←DEF_RX next cycle. If a TX LF accept and an RX LF read occur in the same cycle, the TX assignment wins (rx_owner←o).
- Widths: watchdog $clog2(TMO_CYCLES+1) bits, saturating. rr_ptr wraps N_REQ-1 → 0.

## Timing
- Request to grant: 1 cycle (req set at edge k, grant visible after edge k+1).
- Grant to first byte: 0 cycles; the owner may assert tx_valid in the grant's first cycle.
- tx_full: valid_tx forced 0 while full; the requester holds tx_valid/tx_data until it is accepted. Arbiter holds no backpressure state.
- Release/revocation to next grant: 2 cycles minimum (BUSY→IDLE, IDLE→BUSY).
- rx_owner update: 1 cycle after the qualifying LF; rd_en routing uses the registered value.
- Reset mid-packet: grant and valid_tx drop immediately (async); partial packet abandoned, no flush.

## Test plan
- Single requester: req[1]=1, send "AT\r\n" with tx_full=0 -> grant=0010 one cycle after req; UART gets 0x41,0x54,0x0D,0x0A on 4 consecutive cycles; rx_owner=1 one cycle after LF.
- Round-robin fairness: req=1111 held, each owner sends one byte then drops req for one cycle -> grants in order 0,1,2,3,0; never two bits set in grant.
- Backpressure: owner streams 8 bytes while tx_full toggles every 3 cycles -> valid_tx never high while tx_full=1; all 8 bytes received in order.
- Watchdog: TMO_CYCLES=16, owner 2 granted, never asserts tx_valid -> timeout_err pulses exactly once 16 cycles after grant; grant=0; req[3] is granted 1 cycle later.
- RX routing: after owner 1 sends LF, drive "OK\r\n" with rx_rd_en[1]=1 and rx_rd_en[0]=1 -> only requester 1's reads reach rd_fifo_rd_en; after the 0x0A read rx_owner=DEF_RX=0.
- Async reset asserted mid-packet -> grant=0, valid_tx=0, rx_owner=0 without a clock edge; after release, first req is granted normally.
